serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor. Computes diff = a - b - bin one bit per clock, LSB first.
- One internal full-subtractor cell (d = x ^ y ^ br; br_next = (~x & y) | (~(x ^ y) & br)) plus a borrow flip-flop.
- Operands and borrow-in are latched on a start/done handshake.
- Used where area matters more than latency. It is the subtract-direction counterpart to the team's dataflow full-adder arithmetic.

---
 rtl/serial_subtractor.sv | 154 +++++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, LSB first,
// one bit per clock. A single full-subtractor cell and a borrow flip-flop
// are reused across all bit positions. The cell trades latency for area.
//
// Operation:
//   - In IDLE or DONE, start = 1 loads a, b and bin. The machine then spends
//     WIDTH cycles in SHIFT.
//   - The edge that processes the last bit updates diff, bout and ovf and
//     raises done for exactly one cycle.
//   - diff, bout and ovf hold their previous result while a new operation
//     runs, and keep it after completion until the next result or reset.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      begin a subtraction (ignored while busy)
//   a      in   WIDTH  minuend, sampled with start
//   b      in   WIDTH  subtrahend, sampled with start
//   bin    in   1      borrow-in, sampled with start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle completion pulse
//   diff   out  WIDTH  (a - b - bin) mod 2^WIDTH
//   bout   out  1      unsigned borrow-out (a < b + bin)
//   ovf    out  1      two's-complement overflow of the subtraction
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;

    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // Full-subtractor cell acting on the current LSBs and the stored borrow.
    assign w_x        = r_a[0];
    assign w_y        = r_b[0];
    assign w_d        = w_x ^ w_y ^ r_br;
    assign w_br_next  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    // Result bits enter at the MSB end, so after WIDTH shifts bit 0 sits at
    // position 0.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // NOTE: every register here is updated with non-blocking assignments so
    // that all of them see the values from before the edge. A blocking
    // assignment would let later statements read the updated value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the operand and result shift registers are reset as well.
            // An aborted run then leaves no residue behind.
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                SHIFT: begin
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_res <= w_res_next;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        // w_d is the result MSB on this final edge.
                        r_diff  <= w_res_next;
                        r_bout  <= w_br_next;
                        r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign diff = r_diff;
    assign bout = r_bout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor. An 8-bit instance covers the
// directed cases, the handshake corner cases, reset abort and random
// operands. A 4-bit instance is swept over every (a, b, bin) combination.
// Expected values come from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       bin8;
    logic       busy8, done8, bout8, ovf8;
    logic [7:0] diff8;

    logic       start4;
    logic [3:0] a4, b4;
    logic       bin4;
    logic       busy4, done4, bout4, ovf4;
    logic [3:0] diff4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk  (clk),
        .rst  (rst),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .bin  (bin8),
        .busy (busy8),
        .done (done8),
        .diff (diff8),
        .bout (bout8),
        .ovf  (ovf8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .start(start4),
        .a    (a4),
        .b    (b4),
        .bin  (bin4),
        .busy (busy4),
        .done (done4),
        .diff (diff4),
        .bout (bout4),
        .ovf  (ovf4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: arithmetic on plain integers, signed overflow taken as the
    // true signed difference leaving the w-bit range.
    function automatic void model(input int w, input int a, input int b, input int bin,
                                  output int d, output int bo, output int ov);
        int sa, sb, r;
        d  = (a - b - bin) & ((1 << w) - 1);
        bo = (a < b + bin) ? 1 : 0;
        sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
        sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
        r  = sa - sb - bin;
        ov = (r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1) ? 1 : 0;
    endfunction

    // Called just after a falling edge: presents operands for one rising
    // edge, then scrambles them to show they are not used after loading.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    endtask

    // Counts falling edges from the first post-load sample until done, bounded.
    task automatic wait_done8(output int n, output int nb);
        n = 0; nb = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_res8(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic bin);
        int d, bo, ov;
        model(8, int'(a), int'(b), int'(bin), d, bo, ov);
        check({tag, ".diff"}, 32'(diff8), 32'(d));
        check({tag, ".bout"}, 32'(bout8), 32'(bo));
        check({tag, ".ovf"},  32'(ovf8),  32'(ov));
    endtask

    task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bin);
        int n, nb;
        launch8(a, b, bin);
        wait_done8(n, nb);
        check({tag, ".latency"}, 32'(n), 32'd8);
        check({tag, ".busy_cycles"}, 32'(nb), 32'd8);
        check_res8(tag, a, b, bin);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(done8), 32'd0);
        check_res8({tag, ".hold"}, a, b, bin);
    endtask

    initial begin
        logic [7:0] va [7];
        logic [7:0] vb [7];
        logic       vbin [7];
        int n, nb;

        va   = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'h00, 8'h5A};
        vb   = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h5A};
        vbin = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(busy8), 0);
        check("rst.done", 32'(done8), 0);
        check("rst.diff", 32'(diff8), 0);
        check("rst.bout", 32'(bout8), 0);
        check("rst.ovf",  32'(ovf8),  0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, including the zero, equal and wrap-around corners.
        for (int i = 0; i < 7; i++) begin
            do_op8($sformatf("dir%0d", i), va[i], vb[i], vbin[i]);
        end

        // A start pulse while busy must be ignored.
        launch8(8'h10, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("ign.busy", 32'(busy8), 1);
        wait_done8(n, nb);
        check("ign.latency", 32'(n + 3), 32'd8);
        check_res8("ign", 8'h10, 8'h01, 1'b0);

        // Start in the done cycle: the new operation loads with no gap.
        launch8(8'h20, 8'h03, 1'b0);
        check("b2b.busy", 32'(busy8), 1);
        check("b2b.done", 32'(done8), 0);
        check("b2b.diff_held", 32'(diff8), 32'h0F);
        wait_done8(n, nb);
        check("b2b.latency", 32'(n), 32'd8);
        check_res8("b2b", 8'h20, 8'h03, 1'b0);
        @(negedge clk);

        // Reset in the middle of an operation discards the partial result.
        launch8(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        check("abort.busy_before", 32'(busy8), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", 32'(busy8), 0);
        check("abort.done", 32'(done8), 0);
        check("abort.diff", 32'(diff8), 0);
        check("abort.bout", 32'(bout8), 0);
        check("abort.ovf",  32'(ovf8),  0);
        do_op8("after_abort", 8'hAA, 8'h55, 1'b0);

        // Random operands with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_op8($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Exhaustive 4-bit sweep; each new start lands in the previous done cycle.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    int d, bo, ov, m;
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
                    m = 0;
                    while (!done4 && m < 20) begin
                        @(negedge clk);
                        m++;
                    end
                    model(4, ia, ib, ic, d, bo, ov);
                    check($sformatf("w4 lat a=%0d b=%0d bin=%0d", ia, ib, ic), 32'(m), 32'd4);
                    check($sformatf("w4 {diff,bout,ovf} a=%0d b=%0d bin=%0d", ia, ib, ic),
                          {26'd0, diff4, bout4, ovf4}, 32'((d << 2) | (bo << 1) | ov));
                end
            end
        end
        @(negedge clk);
        check("w4.done_drop", 32'(done4), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
